latch_stim_checker: RTL

Clocked stimulus driver and self-checker for a gated D-latch DUT with outputs P/Pn. It replays stored G/D gate/data patterns onto the DUT one step at a time and samples P/Pn after a settle interval. Each sample is compared against an internal latch reference model, and mismatches are counted. It sits on the board-test side of the latch labs and replaces a simulation-only bench with a synthesizable pass/fail checker.

---
 rtl/latch_chk_pkg.sv | 26 ++
 rtl/latch_ref_model.sv | 53 +++++
 rtl/latch_stim_checker.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/latch_chk_pkg.sv
// latch_chk_pkg
//   Shared types and default constants for the gated D-latch stimulus checker.
//   state_e      : checker FSM states
//   DEF_*        : default pattern and timing constants
//   idx_width()  : width of a step index for a pattern of n steps
package latch_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_HOLD,
    ST_DONE
  } state_e;

  localparam int                   DEF_LEN           = 9;
  localparam logic [DEF_LEN-1:0]   DEF_G_PATTERN     = 9'b011001100;
  localparam logic [DEF_LEN-1:0]   DEF_D_PATTERN     = 9'b001101001;
  localparam int                   DEF_STEP_CYCLES   = 10;
  localparam int                   DEF_SETTLE_CYCLES = 1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/latch_ref_model.sv
// latch_ref_model
//   Golden gated D-latch used by the checker.
//   clk, rst_n : clock, async active-low reset
//   clr        : forget the stored value (value 0, valid 0)
//   upd        : sample strobe; with g high the latch loads d
//   g, d       : gate and data of the step being sampled
//   q, valid   : latch value and "has ever been loaded" flag
// q/valid are the post-update view: during an update with g high they are
// transparent to d, just like the real latch, so the caller can compare in
// the same cycle.
module latch_ref_model (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic upd,
  input  logic g,
  input  logic d,
  output logic q,
  output logic valid
);

  logic q_q, q_d;
  logic valid_q, valid_d;
  logic load;

  assign load = upd & g;

  always_comb begin
    q_d     = q_q;
    valid_d = valid_q;
    if (clr) begin
      q_d     = 1'b0;
      valid_d = 1'b0;
    end else if (load) begin
      q_d     = d;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign q     = load ? d : q_q;
  assign valid = valid_q | load;

endmodule

// File: rtl/latch_stim_checker.sv
// latch_stim_checker
//   Replays G/D patterns onto a gated D-latch, samples P/Pn after a settle
//   interval and counts mismatches against latch_ref_model.
//   clk, rst_n      : clock, async active-low reset
//   start           : begin a run (honoured only in IDLE/DONE)
//   G, D            : stimulus to the latch under test
//   P, Pn           : latch outputs
//   busy, done,pass : run status
//   error_count     : mismatches of the current/last run
//   step_idx        : step currently driven
//   cap_p, cap_pn   : sampled P/Pn per step (only with LATCH_CHK_TRACE_EN,
//                     otherwise tied to 0)
//
// state  | meaning
// IDLE   | after reset, outputs 0, waiting for start
// DRIVE  | pattern step applied, waiting SETTLE_CYCLES
// SAMPLE | model update, P/Pn compare, error accumulate (1 cycle)
// HOLD   | pad the step out to STEP_CYCLES
// DONE   | run finished, result held until next start
//
// start is registered once before the run begins, so step 0 is driven one
// cycle after the edge that sees start.
module latch_stim_checker
  import latch_chk_pkg::*;
#(
  parameter int             LEN           = DEF_LEN,
  parameter logic [LEN-1:0] G_PATTERN     = DEF_G_PATTERN,
  parameter logic [LEN-1:0] D_PATTERN     = DEF_D_PATTERN,
  parameter int             STEP_CYCLES   = DEF_STEP_CYCLES,
  parameter int             SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int             ERR_W         = $clog2(2*LEN+1),
  parameter int             IDX_W         = idx_width(LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             G,
  output logic             D,
  input  logic             P,
  input  logic             Pn,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] error_count,
  output logic [IDX_W-1:0] step_idx,
  output logic [LEN-1:0]   cap_p,
  output logic [LEN-1:0]   cap_pn
);

  localparam int HOLD_CYCLES = STEP_CYCLES - SETTLE_CYCLES - 1;
  localparam int TMR_W       = $clog2(STEP_CYCLES + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] step_idx_q, step_idx_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             start_seen_q, start_seen_d;
  logic             g_bit, d_bit;
  logic             run_start, sample_en, advance, last_step;
  logic             model_q, model_valid, mis_p, mis_pn;

  // Step 0 sits in the pattern MSB.
  always_comb begin
    g_bit = 1'b0;
    d_bit = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      if (step_idx_q == IDX_W'(i)) begin
        g_bit = G_PATTERN[LEN-1-i];
        d_bit = D_PATTERN[LEN-1-i];
      end
    end
  end

  assign last_step = (step_idx_q == IDX_W'(LEN-1));
  assign mis_p     = model_valid & (P  != model_q);
  assign mis_pn    = model_valid & (Pn != ~model_q);

  always_comb begin
    state_d      = state_q;
    step_idx_d   = step_idx_q;
    err_d        = err_q;
    tmr_d        = tmr_q;
    start_seen_d = 1'b0;
    run_start    = 1'b0;
    sample_en    = 1'b0;
    advance      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        start_seen_d = start & ~start_seen_q;
        if (start_seen_q) begin
          state_d    = ST_DRIVE;
          run_start  = 1'b1;
          step_idx_d = '0;
          err_d      = '0;
          tmr_d      = TMR_W'(SETTLE_CYCLES - 1);
        end
      end
      ST_DRIVE: begin
        if (tmr_q == '0) state_d = ST_SAMPLE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      ST_SAMPLE: begin
        sample_en = 1'b1;
        err_d     = err_q + ERR_W'(mis_p) + ERR_W'(mis_pn);
        if (HOLD_CYCLES == 0) begin
          advance = 1'b1;
        end else begin
          state_d = ST_HOLD;
          tmr_d   = TMR_W'(HOLD_CYCLES - 1);
        end
      end
      ST_HOLD: begin
        if (tmr_q == '0) advance = 1'b1;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (advance) begin
      if (last_step) begin
        state_d = ST_DONE;
      end else begin
        state_d    = ST_DRIVE;
        step_idx_d = step_idx_q + IDX_W'(1);
        tmr_d      = TMR_W'(SETTLE_CYCLES - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      step_idx_q   <= '0;
      err_q        <= '0;
      tmr_q        <= '0;
      start_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_idx_q   <= step_idx_d;
      err_q        <= err_d;
      tmr_q        <= tmr_d;
      start_seen_q <= start_seen_d;
    end
  end

  latch_ref_model u_model (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (run_start),
    .upd   (sample_en),
    .g     (g_bit),
    .d     (d_bit),
    .q     (model_q),
    .valid (model_valid)
  );

  assign busy        = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE) || (state_q == ST_HOLD);
  assign G           = busy & g_bit;
  assign D           = busy & d_bit;
  assign done        = (state_q == ST_DONE);
  assign pass        = done & (err_q == '0);
  assign error_count = err_q;
  assign step_idx    = step_idx_q;

`ifdef LATCH_CHK_TRACE_EN
  logic [LEN-1:0] cap_p_q, cap_p_d, cap_pn_q, cap_pn_d;

  always_comb begin
    cap_p_d  = cap_p_q;
    cap_pn_d = cap_pn_q;
    if (run_start) begin
      cap_p_d  = '0;
      cap_pn_d = '0;
    end else if (sample_en) begin
      for (int i = 0; i < LEN; i++) begin
        if (step_idx_q == IDX_W'(i)) begin
          cap_p_d[LEN-1-i]  = P;
          cap_pn_d[LEN-1-i] = Pn;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_p_q  <= '0;
      cap_pn_q <= '0;
    end else begin
      cap_p_q  <= cap_p_d;
      cap_pn_q <= cap_pn_d;
    end
  end

  assign cap_p  = cap_p_q;
  assign cap_pn = cap_pn_q;
`else
  assign cap_p  = '0;
  assign cap_pn = '0;
`endif

endmodule
